// File: rtl/buscador_maximo.sv
// Streaming max-finder: tracks the running maximum of each fixed-length frame using an
// external greater-than comparator, then presents {max, index} on a valid/ready output.
module buscador_maximo #(
    parameter int N     = 5,
    parameter int LEN   = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    output logic             in_ready,
    output logic [N-1:0]     cmp_a,
    output logic [N-1:0]     cmp_b,
    input  logic             cmp_mayor,
    output logic             max_valid,
    output logic [N-1:0]     max_data,
    output logic [IDX_W-1:0] max_idx,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        ST_FIRST,
        ST_ACC,
        ST_OUT
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(LEN - 1);

    state_t           state_q;
    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] cnt_d;
    logic [IDX_W-1:0] idx_q;
    logic [N-1:0]     max_q;
    logic             in_ready_q;
    logic             max_valid_q;
    logic             accept_in;
    logic             accept_out;

    assign accept_in  = in_valid & in_ready_q;
    assign accept_out = max_valid_q & out_ready;
    assign cnt_d      = cnt_q + 1'b1;

    // The comparator is combinational, so its verdict is consumed in the same cycle.
    assign cmp_a = in_data;
    assign cmp_b = max_q;

    assign in_ready  = in_ready_q;
    assign max_valid = max_valid_q;
    assign max_data  = max_q;
    assign max_idx   = idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FIRST;
            cnt_q       <= '0;
            max_q       <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            max_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_FIRST: begin
                    if (accept_in) begin
                        // First sample seeds the maximum; the comparator result is irrelevant here.
                        max_q <= in_data;
                        idx_q <= '0;
                        cnt_q <= IDX_W'(1);
                        if (LEN == 1) begin
                            cnt_q       <= '0;
                            state_q     <= ST_OUT;
                            in_ready_q  <= 1'b0;
                            max_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_ACC;
                        end
                    end
                end
                ST_ACC: begin
                    if (accept_in) begin
                        if (cmp_mayor) begin
                            max_q <= in_data;
                            idx_q <= cnt_q;
                        end
                        if (cnt_q == LAST) begin
                            cnt_q       <= '0;
                            state_q     <= ST_OUT;
                            in_ready_q  <= 1'b0;
                            max_valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                ST_OUT: begin
                    if (accept_out) begin
                        state_q     <= ST_FIRST;
                        cnt_q       <= '0;
                        in_ready_q  <= 1'b1;
                        max_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_FIRST;
                    cnt_q       <= '0;
                    in_ready_q  <= 1'b1;
                    max_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buscador_maximo.sv
// Directed bench for buscador_maximo: table of frames with hand-computed {max, idx},
// plus sequences for backpressure, mid-frame reset, reset in output state and forced compare.
module tb_buscador_maximo;

    localparam int N     = 5;
    localparam int LEN   = 8;
    localparam int IDX_W = 3;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [N-1:0]     in_data;
    logic             in_ready;
    logic [N-1:0]     cmp_a;
    logic [N-1:0]     cmp_b;
    logic             cmp_mayor;
    logic             max_valid;
    logic [N-1:0]     max_data;
    logic [IDX_W-1:0] max_idx;
    logic             out_ready;
    logic             force_mayor;

    int total;
    int bad;

    // Behavioural stand-in for comparador_mayor, with an override to force the verdict.
    assign cmp_mayor = force_mayor | (cmp_a > cmp_b);

    buscador_maximo #(.N(N), .LEN(LEN), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .cmp_mayor (cmp_mayor),
        .max_valid (max_valid),
        .max_data  (max_data),
        .max_idx   (max_idx),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [LEN-1:0][N-1:0] v;
        int                    emax;
        int                    eidx;
        bit                    gaps;
        int                    force_k;
    } vec_t;

    vec_t tbl[7];

    function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3,
                                input int a4, input int a5, input int a6, input int a7,
                                input int emax, input int eidx, input bit gaps, input int fk);
        vec_t r;
        r.v[0] = N'(a0); r.v[1] = N'(a1); r.v[2] = N'(a2); r.v[3] = N'(a3);
        r.v[4] = N'(a4); r.v[5] = N'(a5); r.v[6] = N'(a6); r.v[7] = N'(a7);
        r.emax    = emax;
        r.eidx    = eidx;
        r.gaps    = gaps;
        r.force_k = fk;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Streams one frame; rmax/ridx track the expected stored maximum for cmp_b checks.
    task automatic send_frame(input logic [LEN-1:0][N-1:0] v, input bit gaps, input int fk);
        int rmax;
        int ridx;
        rmax = 0;
        ridx = 0;
        for (int k = 0; k < LEN; k++) begin
            if (gaps) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid    = 1'b1;
            in_data     = v[k];
            force_mayor = (k == fk);
            #1;
            check("in_ready_in_frame", int'(in_ready), 1);
            check("max_valid_in_frame", int'(max_valid), 0);
            check("cmp_a", int'(cmp_a), int'(v[k]));
            if (k > 0) check("cmp_b", int'(cmp_b), rmax);
            @(posedge clk);
            #1;
            if (k == 0 || int'(v[k]) > rmax || k == fk) begin
                rmax = int'(v[k]);
                ridx = k;
            end
            force_mayor = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic take_result(input int emax, input int eidx);
        check("max_valid_out", int'(max_valid), 1);
        check("in_ready_out", int'(in_ready), 0);
        check("max_data", int'(max_data), emax);
        check("max_idx", int'(max_idx), eidx);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("max_valid_after_take", int'(max_valid), 0);
        check("in_ready_after_take", int'(in_ready), 1);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        force_mayor = 1'b0;

        tbl[0] = mk( 3, 17,  9, 17, 31,  0, 12,  5, 31, 4, 1'b0, -1);
        tbl[1] = mk(20, 20, 20, 20, 20, 20, 20, 20, 20, 0, 1'b0, -1);
        tbl[2] = mk( 0,  0,  0,  0,  0,  0,  0,  0,  0, 0, 1'b0, -1);
        tbl[3] = mk( 1,  2,  3,  4,  5,  6,  7,  8,  8, 7, 1'b1, -1);
        tbl[4] = mk(31,  0,  0,  0,  0,  0,  0,  0, 31, 0, 1'b0, -1);
        tbl[5] = mk( 9,  9,  9,  9,  9,  9,  9,  9,  9, 3, 1'b0,  3);
        tbl[6] = mk( 4, 12, 12, 30, 30,  1, 30,  2, 30, 3, 1'b1, -1);

        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_max_valid", int'(max_valid), 0);
        check("reset_max_data", int'(max_data), 0);
        check("reset_max_idx", int'(max_idx), 0);

        for (int t = 0; t < 7; t++) begin
            send_frame(tbl[t].v, tbl[t].gaps, tbl[t].force_k);
            take_result(tbl[t].emax, tbl[t].eidx);
        end

        // Backpressure: result must hold while out_ready is low and no sample is taken.
        begin
            logic [LEN-1:0][N-1:0] f;
            f = mk(1, 2, 3, 4, 5, 6, 7, 31, 0, 0, 1'b0, -1).v;
            send_frame(f, 1'b1, -1);
            in_valid = 1'b1;
            in_data  = 5'd30;
            for (int i = 0; i < 5; i++) begin
                check("bp_max_valid", int'(max_valid), 1);
                check("bp_in_ready", int'(in_ready), 0);
                check("bp_max_data", int'(max_data), 31);
                check("bp_max_idx", int'(max_idx), 7);
                tick();
            end
            in_valid = 1'b0;
            take_result(31, 7);
            f = mk(30, 1, 2, 3, 4, 5, 6, 7, 0, 0, 1'b0, -1).v;
            send_frame(f, 1'b0, -1);
            take_result(30, 0);
        end

        // Reset mid-frame discards the partial frame.
        in_valid = 1'b1;
        in_data  = 5'd31;
        for (int i = 0; i < 4; i++) tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_max_valid", int'(max_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_max_data", int'(max_data), 0);
        send_frame(tbl[3].v, 1'b0, -1);
        take_result(8, 7);

        // Reset while a result is pending drops it.
        send_frame(tbl[0].v, 1'b0, -1);
        check("pend_max_valid", int'(max_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("outrst_max_valid", int'(max_valid), 0);
        check("outrst_in_ready", int'(in_ready), 1);
        send_frame(tbl[1].v, 1'b0, -1);
        take_result(20, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
